// File: rtl/input_pkg.sv
// Shared definitions for the player input conditioning slice:
// button indices, jump request FSM encodings and direction memory values.
package input_pkg;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_JUMP   = 2;
    localparam int BTN_ATTACK = 3;
    localparam int BTN_COUNT  = 4;

    typedef enum logic [1:0] {
        JS_IDLE = 2'b00,
        JS_PEND = 2'b01,
        JS_WAIT = 2'b10
    } jump_state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, persistence counter and accepted stable level,
// with a single-clock rise pulse on the clock the stable level goes high.
module btn_debounce #(
    parameter int                    DB_WIDTH  = 16,
    parameter logic [DB_WIDTH-1:0]   DB_CYCLES = DB_WIDTH'(50000)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic st,
    output logic rise
);

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_CYCLES - DB_WIDTH'(1);

    logic                sync_q1;
    logic                sync_q2;
    logic [DB_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            st      <= 1'b0;
            rise    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            if (sync_q2 == st) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                // New level has persisted long enough: accept it.
                st   <= ~st;
                rise <= ~st;
                cnt  <= '0;
            end else begin
                cnt <= cnt + DB_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/player_input_ctrl.sv
// Conditions raw player buttons into move/jump/attack requests for player_move.
// Optional build macro INPUT_SOCD_LAST_WINS_EN: last-pressed direction wins when both held.
//
// Jump FSM
//   state   | meaning
//   JS_IDLE | no jump request outstanding
//   JS_PEND | jump asserted, waiting for a grounded SCEN tick to consume it
//   JS_WAIT | press buffered while airborne, jbuf SCEN ticks remaining
module player_input_ctrl
    import input_pkg::*;
#(
    parameter int                  DB_WIDTH       = 16,
    parameter logic [DB_WIDTH-1:0] DB_CYCLES      = DB_WIDTH'(50000),
    parameter logic [2:0]          JUMP_BUF_TICKS = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       jump_active,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       attack_req,
    output logic [3:0] btn_state
);

    logic [BTN_COUNT-1:0] btn_raw;
    logic [BTN_COUNT-1:0] st_vec;
    logic [BTN_COUNT-1:0] rise_vec;

    assign btn_raw = {btn_attack, btn_jump, btn_right, btn_left};

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_db
        btn_debounce #(
            .DB_WIDTH  (DB_WIDTH),
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[i]),
            .st    (st_vec[i]),
            .rise  (rise_vec[i])
        );
    end

    assign btn_state = st_vec;

    logic left_nxt;
    logic right_nxt;

`ifdef INPUT_SOCD_LAST_WINS_EN
    dir_e last_dir;
    dir_e last_dir_nxt;

    always_comb begin
        last_dir_nxt = last_dir;
        // Simultaneous rises are resolved towards right.
        if (rise_vec[BTN_RIGHT]) begin
            last_dir_nxt = DIR_RIGHT;
        end else if (rise_vec[BTN_LEFT]) begin
            last_dir_nxt = DIR_LEFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_dir <= DIR_LEFT;
        end else begin
            last_dir <= last_dir_nxt;
        end
    end

    always_comb begin
        left_nxt  = st_vec[BTN_LEFT]
                    & (~st_vec[BTN_RIGHT] | (last_dir_nxt == DIR_LEFT));
        right_nxt = st_vec[BTN_RIGHT]
                    & (~st_vec[BTN_LEFT] | (last_dir_nxt == DIR_RIGHT));
    end
`else
    logic dir_rise_unused;
    assign dir_rise_unused = rise_vec[BTN_LEFT] ^ rise_vec[BTN_RIGHT];

    always_comb begin
        left_nxt  = st_vec[BTN_LEFT] & ~st_vec[BTN_RIGHT];
        right_nxt = st_vec[BTN_RIGHT] & ~st_vec[BTN_LEFT];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            move_left  <= left_nxt;
            move_right <= right_nxt;
        end
    end

    jump_state_e state;
    jump_state_e state_nxt;
    logic [2:0]  jbuf;
    logic [2:0]  jbuf_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= JS_IDLE;
            jbuf  <= 3'd0;
        end else begin
            state <= state_nxt;
            jbuf  <= jbuf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        jbuf_nxt  = jbuf;
        case (state)
            JS_IDLE: begin
                if (rise_vec[BTN_JUMP]) begin
                    if (jump_active) begin
                        state_nxt = JS_WAIT;
                        jbuf_nxt  = JUMP_BUF_TICKS;
                    end else begin
                        state_nxt = JS_PEND;
                    end
                end
            end
            JS_PEND: begin
                if (jump_active) begin
                    state_nxt = JS_WAIT;
                    jbuf_nxt  = JUMP_BUF_TICKS;
                end else if (SCEN) begin
                    state_nxt = JS_IDLE;
                end
            end
            JS_WAIT: begin
                if (!jump_active) begin
                    state_nxt = JS_PEND;
                    jbuf_nxt  = 3'd0;
                end else if (SCEN) begin
                    // Buffer exhausted while still airborne: drop the press.
                    if (jbuf <= 3'd1) begin
                        state_nxt = JS_IDLE;
                        jbuf_nxt  = 3'd0;
                    end else begin
                        jbuf_nxt = jbuf - 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = JS_IDLE;
                jbuf_nxt  = 3'd0;
            end
        endcase
    end

    assign jump = (state == JS_PEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            attack_req <= 1'b0;
        end else if (rise_vec[BTN_ATTACK]) begin
            attack_req <= 1'b1;
        end else if (SCEN) begin
            attack_req <= 1'b0;
        end
    end

endmodule
